// File: rtl/matrix_bram_bank_if.sv
// Host-side bundle for matrix_bram_bank: command channel, matrix dimensions,
// write stream into A/B and the C readback stream.
//
// Handshake rule for every channel here: a transfer happens on the rising
// clock edge where valid and ready are both high; valid must not wait for
// ready, and a producer holds its payload stable while valid is high and
// ready is low.
interface matrix_bram_bank_if #(
    parameter int MAX_M = 16,
    parameter int MAX_K = 16,
    parameter int MAX_N = 16
);
    logic [$clog2(MAX_M):0] cfg_M;
    logic [$clog2(MAX_K):0] cfg_K;
    logic [$clog2(MAX_N):0] cfg_N;

    logic                   cmd_valid;
    logic [1:0]             cmd;
    logic                   cmd_ready;

    logic                   in_valid;
    logic [31:0]            in_data;
    logic                   in_ready;

    logic                   out_valid;
    logic [31:0]            out_data;
    logic                   out_last;
    logic                   out_ready;

    modport master (
        output cfg_M, cfg_K, cfg_N, cmd_valid, cmd, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cfg_M, cfg_K, cfg_N, cmd_valid, cmd, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matrix_bram_bank.sv
// matrix_bram_bank: A/B operand stores and C result store for a matrix engine.
// The host fills A or B through a streaming write port and drains C through a
// buffered readback stream; the engine has free-running 1-cycle read ports on
// A/B and a write port on C.
// Optional feature macro: MATRIX_BANK_OOR_EN adds a sticky out-of-range flag
// (err). Without it, out-of-range engine addresses simply wrap.
module matrix_bram_bank #(
    parameter int MAX_M       = 16,
    parameter int MAX_K       = 16,
    parameter int MAX_N       = 16,
    parameter int ADDR_A_BITS = $clog2(MAX_M * MAX_K),
    parameter int ADDR_B_BITS = $clog2(MAX_K * MAX_N),
    parameter int ADDR_C_BITS = $clog2(MAX_M * MAX_N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    matrix_bram_bank_if.slave      host,
    input  logic [ADDR_A_BITS-1:0] eng_A_addr,
    output logic [31:0]            eng_A_rdata,
    input  logic [ADDR_B_BITS-1:0] eng_B_addr,
    output logic [31:0]            eng_B_rdata,
    input  logic                   eng_C_we,
    input  logic [ADDR_C_BITS-1:0] eng_C_addr,
    input  logic [31:0]            eng_C_wdata,
`ifdef MATRIX_BANK_OOR_EN
    output logic                   err,
`endif
    output logic [1:0]             dbg_state,
    output logic                   busy
);
    // Totals and counters are wide enough for the largest product, untruncated.
    localparam int MAX_AB = (ADDR_A_BITS > ADDR_B_BITS) ? ADDR_A_BITS : ADDR_B_BITS;
    localparam int TOT_W  = ((MAX_AB > ADDR_C_BITS) ? MAX_AB : ADDR_C_BITS) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL_A = 2'd1, FILL_B = 2'd2, DRAIN = 2'd3} state_t;

    logic [31:0] mem_a [MAX_M*MAX_K];
    logic [31:0] mem_b [MAX_K*MAX_N];
    logic [31:0] mem_c [MAX_M*MAX_N];

    state_t             state_q, state_d;
    logic [TOT_W-1:0]   cnt_q, cnt_d;        // fill write index / drain read index
    logic [TOT_W-1:0]   out_cnt_q, out_cnt_d; // drain words handed to the host
    logic [TOT_W-1:0]   tot_q, tot_d;
    logic               ready_en_q;          // holds cmd_ready low until the first edge after reset
    logic [31:0]        eng_a_rdata_q, eng_b_rdata_q;

    // Drain pipeline: one in-flight C read feeding a 2-entry output buffer.
    logic               rd_v_q;
    logic [31:0]        rd_data_q;
    logic [31:0]        fifo_mem [2];
    logic               fifo_wp_q, fifo_rp_q;
    logic [1:0]         fifo_cnt_q;

    logic               cmd_ready_w, cmd_accept, out_valid_w, out_last_w, pop, room;
    logic               wr_a, wr_b, rd_issue, tot_zero;
    logic [TOT_W-1:0]   tot_last, m_w, k_w, n_w, prod_mk, prod_kn, prod_mn;
    logic [2:0]         occ;

    assign m_w      = TOT_W'(host.cfg_M);
    assign k_w      = TOT_W'(host.cfg_K);
    assign n_w      = TOT_W'(host.cfg_N);
    assign prod_mk  = m_w * k_w;
    assign prod_kn  = k_w * n_w;
    assign prod_mn  = m_w * n_w;

    assign tot_zero = (tot_q == '0);
    assign tot_last = tot_q - TOT_W'(1);

    assign cmd_ready_w    = (state_q == IDLE) && ready_en_q;
    assign cmd_accept     = host.cmd_valid && cmd_ready_w;
    assign host.cmd_ready = cmd_ready_w;
    assign host.in_ready  = ((state_q == FILL_A) || (state_q == FILL_B)) && !tot_zero;

    assign out_valid_w    = (fifo_cnt_q != 2'd0);
    assign out_last_w     = out_valid_w && (out_cnt_q == tot_last);
    assign pop            = out_valid_w && host.out_ready;
    assign host.out_valid = out_valid_w;
    assign host.out_last  = out_last_w;
    assign host.out_data  = out_valid_w ? fifo_mem[fifo_rp_q] : 32'd0;

    // A new read may issue only if its word is guaranteed a buffer slot on arrival.
    assign occ  = {1'b0, fifo_cnt_q} + {2'b00, rd_v_q};
    assign room = (occ < (3'd2 + {2'b00, pop}));

    assign busy        = (state_q != IDLE);
    assign dbg_state   = state_q;
    assign eng_A_rdata = eng_a_rdata_q;
    assign eng_B_rdata = eng_b_rdata_q;

    // Next-state, counter and transfer-strobe decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_cnt_d = out_cnt_q;
        tot_d     = tot_q;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        rd_issue  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    cnt_d     = '0;
                    out_cnt_d = '0;
                    case (host.cmd)
                        2'b01:   begin tot_d = prod_mk; state_d = FILL_A; end
                        2'b10:   begin tot_d = prod_kn; state_d = FILL_B; end
                        2'b11:   begin tot_d = prod_mn; state_d = DRAIN;  end
                        default: ;
                    endcase
                end
            end
            FILL_A, FILL_B: begin
                if (tot_zero) begin
                    state_d = IDLE;
                end else if (host.in_valid) begin
                    wr_a  = (state_q == FILL_A);
                    wr_b  = (state_q == FILL_B);
                    cnt_d = cnt_q + TOT_W'(1);
                    if (cnt_q == tot_last) state_d = IDLE;
                end
            end
            DRAIN: begin
                if (tot_zero) begin
                    state_d = IDLE;
                end else begin
                    rd_issue = (cnt_q < tot_q) && room;
                    if (rd_issue) cnt_d = cnt_q + TOT_W'(1);
                    if (pop) begin
                        out_cnt_d = out_cnt_q + TOT_W'(1);
                        if (out_last_w) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, counters, drain buffer bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_cnt_q  <= '0;
            tot_q      <= '0;
            ready_en_q <= 1'b0;
            rd_v_q     <= 1'b0;
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_cnt_q  <= out_cnt_d;
            tot_q      <= tot_d;
            ready_en_q <= 1'b1;
            rd_v_q     <= rd_issue;
            if (rd_v_q) fifo_wp_q <= ~fifo_wp_q;
            if (pop)    fifo_rp_q <= ~fifo_rp_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_v_q} - {1'b0, pop};
        end
    end

    // Engine A/B read ports: registered every cycle in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_a_rdata_q <= 32'd0;
            eng_b_rdata_q <= 32'd0;
        end else begin
            eng_a_rdata_q <= mem_a[eng_A_addr];
            eng_b_rdata_q <= mem_b[eng_B_addr];
        end
    end

    // Storage arrays and drain data path; contents survive reset. The C read
    // sees the pre-write value when the engine writes the same word (read-first).
    always_ff @(posedge clk) begin
        if (wr_a)     mem_a[cnt_q[ADDR_A_BITS-1:0]] <= host.in_data;
        if (wr_b)     mem_b[cnt_q[ADDR_B_BITS-1:0]] <= host.in_data;
        if (eng_C_we) mem_c[eng_C_addr]            <= eng_C_wdata;
        if (rd_issue) rd_data_q                    <= mem_c[cnt_q[ADDR_C_BITS-1:0]];
        if (rd_v_q)   fifo_mem[fifo_wp_q]          <= rd_data_q;
    end

`ifdef MATRIX_BANK_OOR_EN
    logic             err_q, oor_hit;
    logic [TOT_W-1:0] tot_a_q, tot_b_q, tot_c_q;

    // Before any command the limits are the full array depths.
    assign oor_hit = (TOT_W'(eng_A_addr) >= tot_a_q) ||
                     (TOT_W'(eng_B_addr) >= tot_b_q) ||
                     (eng_C_we && (TOT_W'(eng_C_addr) >= tot_c_q)) ||
                     ((state_q == IDLE) && ready_en_q && (host.in_valid || host.out_ready));
    assign err = err_q;

    // Sticky error flag; any command accept clears it and refreshes the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            tot_a_q <= TOT_W'(MAX_M * MAX_K);
            tot_b_q <= TOT_W'(MAX_K * MAX_N);
            tot_c_q <= TOT_W'(MAX_M * MAX_N);
        end else if (cmd_accept) begin
            err_q <= 1'b0;
            if (host.cmd == 2'b01) tot_a_q <= prod_mk;
            if (host.cmd == 2'b10) tot_b_q <= prod_kn;
            if (host.cmd == 2'b11) tot_c_q <= prod_mn;
        end else if (oor_hit) begin
            err_q <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_matrix_bram_bank.sv
// Directed bench for matrix_bram_bank: fills, drain latency/throughput,
// backpressure, read-first C access, zero-size command and reset mid-fill.
module tb_matrix_bram_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eng_A_addr, eng_B_addr, eng_C_addr;
  logic [31:0] eng_A_rdata, eng_B_rdata, eng_C_wdata;
  logic        eng_C_we, busy;
  logic [1:0]  dbg_state;
`ifdef MATRIX_BANK_OOR_EN
  logic        err;
`endif
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  matrix_bram_bank_if #(.MAX_M(16), .MAX_K(16), .MAX_N(16)) host_if ();

  matrix_bram_bank #(.MAX_M(16), .MAX_K(16), .MAX_N(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (host_if),
    .eng_A_addr  (eng_A_addr),
    .eng_A_rdata (eng_A_rdata),
    .eng_B_addr  (eng_B_addr),
    .eng_B_rdata (eng_B_rdata),
    .eng_C_we    (eng_C_we),
    .eng_C_addr  (eng_C_addr),
    .eng_C_wdata (eng_C_wdata),
`ifdef MATRIX_BANK_OOR_EN
    .err         (err),
`endif
    .dbg_state   (dbg_state),
    .busy        (busy)
  );

  // driver: present a command for one cycle; returns on the negedge after the accepting edge
  task automatic issue_cmd(input logic [1:0] c, input logic [4:0] m, input logic [4:0] k, input logic [4:0] n);
    host_if.cfg_M = m;
    host_if.cfg_K = k;
    host_if.cfg_N = n;
    host_if.cmd = c;
    host_if.cmd_valid = 1'b1;
    @(negedge clk);
    host_if.cmd_valid = 1'b0;
    host_if.cmd = 2'b00;
  endtask

  task automatic test_reset;
    host_if.cmd_valid = 0; host_if.cmd = 0; host_if.cfg_M = 0; host_if.cfg_K = 0; host_if.cfg_N = 0;
    host_if.in_valid = 0; host_if.in_data = 0; host_if.out_ready = 0;
    eng_A_addr = 0; eng_B_addr = 0; eng_C_addr = 0; eng_C_we = 0; eng_C_wdata = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (host_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", host_if.cmd_ready); end
    n_checks++; if (host_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", host_if.in_ready); end
    n_checks++; if (host_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", host_if.out_valid); end
    n_checks++; if (host_if.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", host_if.out_last); end
    n_checks++; if (host_if.out_data !== 32'd0) begin n_fail++; $display("FAIL rst_out_data: got %0h want 0", host_if.out_data); end
    n_checks++; if (eng_A_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_eng_A_rdata: got %0h want 0", eng_A_rdata); end
    n_checks++; if (eng_B_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_eng_B_rdata: got %0h want 0", eng_B_rdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (host_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready_early: got %b want 0", host_if.cmd_ready); end
    @(negedge clk);
    n_checks++; if (host_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", host_if.cmd_ready); end
  endtask

  task automatic test_fill_a;
    issue_cmd(2'b01, 5'd2, 5'd3, 5'd2);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_a_busy_start: got %b want 1", busy); end
    n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL fill_a_state: got %0d want 1", dbg_state); end
    n_checks++; if (host_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_a_in_ready: got %b want 1", host_if.in_ready); end
    for (int i = 1; i <= 6; i++) begin
      host_if.in_valid = 1'b1;
      host_if.in_data = 32'(i);
      @(negedge clk);
      n_checks++; if (busy !== (i < 6)) begin n_fail++; $display("FAIL fill_a_busy beat %0d: got %b want %b", i, busy, (i < 6)); end
    end
    host_if.in_valid = 1'b0;
    host_if.in_data = 32'd0;
    for (int a = 0; a < 6; a++) begin
      eng_A_addr = 8'(a);
      @(negedge clk);
      n_checks++; if (eng_A_rdata !== 32'(a + 1)) begin n_fail++; $display("FAIL fill_a_rdata addr %0d: got %0d want %0d", a, eng_A_rdata, a + 1); end
    end
  endtask

  task automatic test_fill_b;
    issue_cmd(2'b10, 5'd2, 5'd3, 5'd2);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) begin
        host_if.in_valid = 1'b0;
        host_if.in_data = 32'hdead_beef;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_b_gap_busy word %0d: got %b want 1", i, busy); end
      end
      host_if.in_valid = 1'b1;
      host_if.in_data = 32'(7 + i);
      @(negedge clk);
      n_checks++; if (busy !== (i < 5)) begin n_fail++; $display("FAIL fill_b_busy word %0d: got %b want %b", i, busy, (i < 5)); end
    end
    host_if.in_valid = 1'b0;
    host_if.in_data = 32'd0;
    for (int a = 0; a < 6; a++) begin
      eng_B_addr = 8'(a);
      @(negedge clk);
      n_checks++; if (eng_B_rdata !== 32'(7 + a)) begin n_fail++; $display("FAIL fill_b_rdata addr %0d: got %0d want %0d", a, eng_B_rdata, 7 + a); end
    end
  endtask

  task automatic test_drain;
    logic [31:0] cvals [4];
    int cyc;
    cvals = '{32'd58, 32'd64, 32'd139, 32'd154};
    for (int j = 0; j < 4; j++) begin
      eng_C_we = 1'b1; eng_C_addr = 8'(j); eng_C_wdata = cvals[j];
      @(negedge clk);
    end
    eng_C_we = 1'b0;
    exp_q = {32'd58, 32'd64, 32'd139, 32'd154};
    issue_cmd(2'b11, 5'd2, 5'd3, 5'd2);
    n_checks++; if (host_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_latency_1: got %b want 0", host_if.out_valid); end
    host_if.out_ready = 1'b1;
    // engine overwrites C[0] on the same edge the drain reads it: the old value must come out
    eng_C_we = 1'b1; eng_C_addr = 8'd0; eng_C_wdata = 32'd999;
    @(negedge clk);
    eng_C_we = 1'b0;
    n_checks++; if (host_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_latency_2: got %b want 0", host_if.out_valid); end
    @(negedge clk);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 10) begin
      n_checks++; if (host_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid cycle %0d: got %b want 1", cyc, host_if.out_valid); end
      n_checks++; if (host_if.out_data !== exp_q[0]) begin n_fail++; $display("FAIL drain_data cycle %0d: got %0d want %0d", cyc, host_if.out_data, exp_q[0]); end
      n_checks++; if (host_if.out_last !== (exp_q.size() == 1)) begin n_fail++; $display("FAIL drain_last cycle %0d: got %b want %b", cyc, host_if.out_last, (exp_q.size() == 1)); end
      if (host_if.out_valid === 1'b1) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_timeout: %0d words left want 0", exp_q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle_after_last: got %b want 0", busy); end
    n_checks++; if (host_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_no_extra_word: got %b want 0", host_if.out_valid); end
    host_if.out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [3:0]  pat;
    logic        stalled;
    logic [31:0] held;
    int cyc;
    pat = 4'b1001;
    stalled = 1'b0;
    held = 32'd0;
    exp_q = {32'd999, 32'd64, 32'd139, 32'd154};
    issue_cmd(2'b11, 5'd2, 5'd3, 5'd2);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      host_if.out_ready = pat[cyc % 4];
      if (stalled) begin
        n_checks++; if (host_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held cycle %0d: got %b want 1", cyc, host_if.out_valid); end
        n_checks++; if (host_if.out_data !== held) begin n_fail++; $display("FAIL bp_data_stable cycle %0d: got %0d want %0d", cyc, host_if.out_data, held); end
      end
      if (host_if.out_valid === 1'b1) begin
        n_checks++; if (host_if.out_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_data cycle %0d: got %0d want %0d", cyc, host_if.out_data, exp_q[0]); end
        n_checks++; if (host_if.out_last !== (exp_q.size() == 1)) begin n_fail++; $display("FAIL bp_last cycle %0d: got %b want %b", cyc, host_if.out_last, (exp_q.size() == 1)); end
        if (host_if.out_ready) begin
          void'(exp_q.pop_front());
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = host_if.out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_timeout: %0d words left want 0", exp_q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_after_last: got %b want 0", busy); end
    n_checks++; if (host_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate: got %b want 0", host_if.out_valid); end
    host_if.out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_zero_total;
    issue_cmd(2'b11, 5'd0, 5'd3, 5'd2);
    host_if.out_ready = 1'b1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_first: got %b want 1", busy); end
    n_checks++; if (host_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_out_valid_0: got %b want 0", host_if.out_valid); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_back_to_idle: got %b want 0", busy); end
    n_checks++; if (host_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_out_valid_1: got %b want 0", host_if.out_valid); end
    n_checks++; if (host_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_cmd_ready: got %b want 1", host_if.cmd_ready); end
    @(negedge clk);
    n_checks++; if (host_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_out_valid_2: got %b want 0", host_if.out_valid); end
    host_if.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_fill;
    exp_q = {32'd100, 32'd101, 32'd3, 32'd4, 32'd5, 32'd6};
    issue_cmd(2'b01, 5'd2, 5'd3, 5'd2);
    host_if.in_valid = 1'b1;
    host_if.in_data = 32'd100;
    @(negedge clk);
    host_if.in_data = 32'd101;
    @(negedge clk);
    host_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    n_checks++; if (host_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", host_if.in_ready); end
    n_checks++; if (host_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_cmd_ready: got %b want 0", host_if.cmd_ready); end
    n_checks++; if (eng_A_rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_eng_A_rdata: got %0h want 0", eng_A_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (host_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after: got %b want 1", host_if.cmd_ready); end
    for (int a = 0; a < 6; a++) begin
      eng_A_addr = 8'(a);
      @(negedge clk);
      n_checks++; if (eng_A_rdata !== exp_q[a]) begin n_fail++; $display("FAIL midrst_retained addr %0d: got %0d want %0d", a, eng_A_rdata, exp_q[a]); end
    end
    exp_q.delete();
  endtask

`ifdef MATRIX_BANK_OOR_EN
  task automatic test_oor;
    eng_A_addr = 8'd0;
    issue_cmd(2'b01, 5'd2, 5'd3, 5'd2);
    for (int i = 1; i <= 6; i++) begin
      host_if.in_valid = 1'b1;
      host_if.in_data = 32'(i);
      @(negedge clk);
    end
    host_if.in_valid = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_clean: got %b want 0", err); end
    eng_A_addr = 8'd6;
    @(negedge clk);
    eng_A_addr = 8'd0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_set: got %b want 1", err); end
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_sticky: got %b want 1", err); end
    issue_cmd(2'b00, 5'd2, 5'd3, 5'd2);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_clear_on_accept: got %b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_a();
    test_fill_b();
    test_drain();
    test_back_to_back();
    test_zero_total();
    test_reset_mid_fill();
`ifdef MATRIX_BANK_OOR_EN
    test_oor();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_bram_bank.md
MATRIX_BRAM_BANK -- requirements
Module: matrix_bram_bank

Interface
REQ-001 The block SHALL have parameter MAX_M, default 16, maximum row count of A and C.
REQ-002 The block SHALL have parameter MAX_K, default 16, maximum inner dimension.
REQ-003 The block SHALL have parameter MAX_N, default 16, maximum column count of B and C.
REQ-004 The block SHALL have derived parameters ADDR_A_BITS=$clog2(MAX_M*MAX_K), ADDR_B_BITS=$clog2(MAX_K*MAX_N) and ADDR_C_BITS=$clog2(MAX_M*MAX_N), used as array depths and address widths.
REQ-005 The block SHALL have port clk, input, 1 bit, clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-007 The block SHALL have ports cfg_M, cfg_K, cfg_N, input, $clog2(MAX_x)+1 bits each, matrix dimensions, sampled on command accept.
REQ-008 The block SHALL have ports cmd_valid, input, 1 bit, and cmd, input, 2 bits, host command: 00 nop, 01 fill A, 10 fill B, 11 drain C.
REQ-009 The block SHALL have port cmd_ready, output, 1 bit, command accepted when cmd_valid&cmd_ready.
REQ-010 The block SHALL have ports in_valid, input, 1 bit; in_data, input, 32 bits; in_ready, output, 1 bit; host write stream.
REQ-011 The block SHALL have ports out_valid, output, 1 bit; out_data, output, 32 bits; out_last, output, 1 bit; out_ready, input, 1 bit; C readback stream.
REQ-012 The block SHALL have ports eng_A_addr, input, ADDR_A_BITS, and eng_A_rdata, output, 32 bits; eng_B_addr, input, ADDR_B_BITS, and eng_B_rdata, output, 32 bits.
REQ-013 The block SHALL have ports eng_C_we, input, 1 bit; eng_C_addr, input, ADDR_C_BITS; eng_C_wdata, input, 32 bits.
REQ-014 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-015 The block SHALL hold three arrays memA[MAX_M*MAX_K], memB[MAX_K*MAX_N], memC[MAX_M*MAX_N] of 32-bit words, row-major.
REQ-016 The block SHALL register eng_A_rdata<=memA[eng_A_addr] and eng_B_rdata<=memB[eng_B_addr] every cycle, in every state, giving exactly 1-cycle read latency.
REQ-017 The block SHALL write memC[eng_C_addr]<=eng_C_wdata on every cycle with eng_C_we=1, in every state.
REQ-018 The FSM SHALL have states IDLE, FILL_A, FILL_B, DRAIN; cmd_ready=1 only in IDLE.
REQ-019 On accept in IDLE, the block SHALL latch total=M*K (01), K*N (10) or M*N (11), clear cnt, and enter FILL_A/FILL_B/DRAIN; cmd 00 SHALL be ignored.
REQ-020 If the latched total is 0, the block SHALL return to IDLE on the next cycle with no data transferred and out_valid never asserted.
REQ-021 In FILL_A/FILL_B, in_ready SHALL be 1; each in_valid&in_ready cycle SHALL write in_data to memA/memB[cnt] and increment cnt.
REQ-022 On the beat where cnt==total-1, the block SHALL return to IDLE on the next cycle.
REQ-023 In DRAIN, the block SHALL read memC[cnt] with 1-cycle latency into a 2-entry output buffer; out_data/out_valid/out_last SHALL hold stable while out_valid&!out_ready.
REQ-024 After a drain accept, first out_valid SHALL assert 2 cycles later; with out_ready held high, throughput SHALL be 1 word/cycle.
REQ-025 out_last SHALL be 1 exactly on word total-1; the block SHALL return to IDLE the cycle after that word's handshake.
REQ-026 A drain read and an engine C write to the same address in the same cycle SHALL return the old value (read-first).
REQ-027 The block SHALL compute products at width ADDR_x_BITS+1, without truncation, for dimensions up to MAX values.

Reset
REQ-028 While rst_n=0, the block SHALL hold state=IDLE and cnt=0, and drive cmd_ready=0, in_ready=0, out_valid=0, out_last=0, out_data=0, eng_A_rdata=0, eng_B_rdata=0, busy=0.
REQ-029 Reset mid-transfer SHALL abandon the transfer; array contents SHALL NOT be cleared by reset.
REQ-030 cmd_ready SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-031 With macro MATRIX_BANK_OOR_EN defined, the block SHALL add output err, 1 bit, sticky, cleared by reset or by a command accept; err SHALL set when an engine address is >= the last-latched total for its array, or when in_valid or out_ready is high in IDLE.
REQ-032 Without MATRIX_BANK_OOR_EN, port err and its logic SHALL be absent; out-of-range accesses SHALL wrap modulo the array depth.

Verification
REQ-033 Fill A: cfg 2x3x2, cmd 01, words 1..6 back-to-back -> busy for 6 beats, then IDLE; engine addr 4 -> eng_A_rdata=5 one cycle later.
REQ-034 Fill B: cmd 10, words 7..12 with in_valid gaps -> memB[0..5]=7..12, cnt advances only on handshakes.
REQ-035 Drain: engine writes C[0..3]=58,64,139,154; cmd 11 with out_ready=1 -> 4 words in order, first out_valid 2 cycles after accept, out_last on 154.
REQ-036 Backpressure: drain with out_ready toggling 1,0,0,1 -> no word lost or duplicated; out_data stable while stalled.
REQ-037 Edge and reset: cfg_M=0 with cmd 11 -> IDLE after 1 cycle, no out_valid; rst_n low mid-fill -> IDLE, prior memA words retained.
REQ-038 With MATRIX_BANK_OOR_EN defined: eng_A_addr=6 after a 2x3 fill -> err=1; the next command accept -> err=0.
